// File: rtl/shift_pipe_pkg.sv
// Shared types and constants for the pipelined shift/rotate unit.
package shift_pkg;
  localparam int DATA_W     = 32;
  localparam int PIPE_DEPTH = 3;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } shift_op_t;
endpackage

// File: rtl/shift_pipe_if.sv
// Operand/result handshake bundle; master drives operands, slave is the shift unit.
interface shift_pipe_if #(parameter int TAG_W = 4);
  logic                         in_valid;
  logic                         in_ready;
  logic [shift_pkg::DATA_W-1:0] in_data;
  logic [4:0]                   in_shamt;
  logic [1:0]                   in_op;
  logic [TAG_W-1:0]             in_tag;
  logic                         out_valid;
  logic                         out_ready;
  logic [shift_pkg::DATA_W-1:0] out_data;
  logic [TAG_W-1:0]             out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_pipe_step.sv
// One fixed-distance shift/rotate step; rotate wrap exists only with SHIFT_PIPE_ROTATE_EN.
module shift_step
  import shift_pkg::*;
#(
  parameter int DIST = 1
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              en_i,
  input  shift_op_t         op_i,
  input  logic              fill_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        OP_SLL:  data_o = data_i << DIST;
        OP_SRL:  data_o = data_i >> DIST;
        // fill_i is the operand's original MSB, so SRA stays correct across stages
        OP_SRA:  data_o = {{DIST{fill_i}}, data_i[DATA_W-1:DIST]};
`ifdef SHIFT_PIPE_ROTATE_EN
        OP_ROTR: data_o = {data_i[DIST-1:0], data_i[DATA_W-1:DIST]};
`else
        OP_ROTR: data_o = data_i;
`endif
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Three-stage 32-bit shift/rotate pipeline with global stall; ROTR enabled by SHIFT_PIPE_ROTATE_EN.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  shift_pipe_if.slave bus
);

  logic              adv;
  shift_op_t         op_in;
  logic [DATA_W-1:0] s16, s8, s4, s2, s1;

  logic              vld_p1_q, vld_p2_q, vld_p3_q;
  logic [DATA_W-1:0] data_p1_q, data_p2_q, data_p3_q;
  logic [2:0]        shamt_p1_q;
  logic              shamt_p2_q;
  shift_op_t         op_p1_q, op_p2_q;
  logic              sign_p1_q, sign_p2_q;
  logic [TAG_W-1:0]  tag_p1_q, tag_p2_q, tag_p3_q;

  // The whole pipe moves as one; a full S3 that is not being taken freezes everything.
  assign adv   = !vld_p3_q || bus.out_ready;
  assign op_in = shift_op_t'(bus.in_op);

  // ---- input -> S1: distances 16 and 8
  shift_step #(.DIST(16)) u_step16 (
    .data_i(bus.in_data), .en_i(bus.in_shamt[4]), .op_i(op_in),
    .fill_i(bus.in_data[DATA_W-1]), .data_o(s16)
  );
  shift_step #(.DIST(8)) u_step8 (
    .data_i(s16), .en_i(bus.in_shamt[3]), .op_i(op_in),
    .fill_i(bus.in_data[DATA_W-1]), .data_o(s8)
  );

  // ---- S1 -> S2: distances 4 and 2
  shift_step #(.DIST(4)) u_step4 (
    .data_i(data_p1_q), .en_i(shamt_p1_q[2]), .op_i(op_p1_q),
    .fill_i(sign_p1_q), .data_o(s4)
  );
  shift_step #(.DIST(2)) u_step2 (
    .data_i(s4), .en_i(shamt_p1_q[1]), .op_i(op_p1_q),
    .fill_i(sign_p1_q), .data_o(s2)
  );

  // ---- S2 -> S3: distance 1
  shift_step #(.DIST(1)) u_step1 (
    .data_i(data_p2_q), .en_i(shamt_p2_q), .op_i(op_p2_q),
    .fill_i(sign_p2_q), .data_o(s1)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else if (adv) begin
      vld_p1_q <= bus.in_valid;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
    end
  end

  always_ff @(posedge clock) begin
    if (adv) begin
      data_p1_q  <= s8;
      shamt_p1_q <= bus.in_shamt[2:0];
      op_p1_q    <= op_in;
      sign_p1_q  <= bus.in_data[DATA_W-1];
      tag_p1_q   <= bus.in_tag;
      data_p2_q  <= s2;
      shamt_p2_q <= shamt_p1_q[0];
      op_p2_q    <= op_p1_q;
      sign_p2_q  <= sign_p1_q;
      tag_p2_q   <= tag_p1_q;
    end
  end

  // S3 feeds the outputs directly, so it also clears to zero on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_p3_q <= '0;
      tag_p3_q  <= '0;
    end else if (adv) begin
      data_p3_q <= s1;
      tag_p3_q  <= tag_p2_q;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_p3_q;
  assign bus.out_data  = data_p3_q;
  assign bus.out_tag   = tag_p3_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed and random traffic against a queue-based reference model.
module tb_shift_pipe;
  import shift_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  shift_pipe_if #(.TAG_W(4)) bus ();

  shift_pipe #(.TAG_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    int          stamp;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          advcnt = 0;
  int          idx;
  logic        acc;
  logic [31:0] rd;
  logic [4:0]  rsh;
  logic [1:0]  rop;
  logic [3:0]  rtag;

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int s, input int op);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      0: return a << s;
      1: return a >> s;
      2: return sa >>> s;
      default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
        if (s == 0) return a;
        return (a >> s) | (a << (32 - s));
`else
        return a;
`endif
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  // One clock cycle: drive, compare outputs against the model, then advance the model.
  // An item presented in cycle c is visible in cycle c+3 when nothing stalls.
  task automatic cycle(input logic r, input logic v, input logic [31:0] d, input logic [4:0] sh,
                       input logic [1:0] op, input logic [3:0] tag, input logic ordy,
                       input logic [31:0] expd, output logic accepted);
    logic exp_ov, exp_ir, pop;
    reset        = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_shamt = sh;
    bus.in_op    = op;
    bus.in_tag   = tag;
    bus.out_ready = ordy;
    #3;
    exp_ov = (q.size() > 0) && ((advcnt - q[0].stamp) >= 2);
    exp_ir = !exp_ov || ordy;
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
    if (exp_ov) begin
      chk("out_data", bus.out_data, q[0].d);
      chk("out_tag", 32'(bus.out_tag), 32'(q[0].t));
    end
    accepted = v && exp_ir && !r;
    pop      = exp_ov && ordy;
    @(posedge clock);
    if (r) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (exp_ir) begin
        advcnt++;
        if (accepted) q.push_back('{d: expd, t: tag, stamp: advcnt});
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 5'd0, 2'd0, 4'd0, 1'b1, 32'h0, a);
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                      input logic [3:0] tag, input logic [31:0] expd);
    logic a;
    cycle(1'b0, 1'b1, d, sh, op, tag, 1'b1, expd, a);
    idle(4);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_op     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clock);
    #1;

    // Directed operations with hand-computed results
    send(32'h000000FF, 5'd8, 2'd0, 4'h5, 32'h0000FF00);
    send(32'h80000000, 5'd31, 2'd2, 4'h6, 32'hFFFFFFFF);
    send(32'h80000000, 5'd31, 2'd1, 4'h7, 32'h00000001);
`ifdef SHIFT_PIPE_ROTATE_EN
    send(32'h12345678, 5'd8, 2'd3, 4'h8, 32'h78123456);
`else
    send(32'h12345678, 5'd8, 2'd3, 4'h8, 32'h12345678);
`endif
    for (int op = 0; op < 4; op++)
      send(32'hDEADBEEF, 5'd0, 2'(op), 4'(op + 9), 32'hDEADBEEF);

    // Stream 1..6 with the consumer stalled in cycles 2..6
    idx = 1;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, idx <= 6, 32'(idx), 5'd0, 2'd0, 4'(idx), !(c >= 2 && c <= 6), 32'(idx), acc);
      if (acc) idx++;
    end
    chk("stream_all_accepted", 32'(idx), 32'd7);

    // Reset with two entries in flight
    cycle(1'b0, 1'b1, 32'hA5A5A5A5, 5'd4, 2'd0, 4'hA, 1'b1, 32'h5A5A5A50, acc);
    cycle(1'b0, 1'b1, 32'h0F0F0F0F, 5'd4, 2'd1, 4'hB, 1'b1, 32'h00F0F0F0, acc);
    cycle(1'b1, 1'b0, 32'h0, 5'd0, 2'd0, 4'h0, 1'b1, 32'h0, acc);
    idle(5);

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      rd   = $urandom;
      rsh  = 5'($urandom_range(0, 31));
      rop  = 2'($urandom_range(0, 3));
      rtag = 4'($urandom_range(0, 15));
      cycle(1'b0, ($urandom % 4) != 0, rd, rsh, rop, rtag, ($urandom % 3) != 0,
            ref_shift(rd, int'(rsh), int'(rop)), acc);
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
